hdr_frame_writer: RTL and testbench

Write-side frame buffer controller directly downstream of the tone mapper. It accepts packed 128-bit words (eight RGB565 pixels) from the tone mapper's `wr_req`/`wr_data` strobe and buffers them in a small FIFO. It generates SDRAM word addresses and issues held write requests to the RAM controller. It rotates across three frame buffers so that the display reader never sees a partially written frame.

---
 rtl/hdr_pkg.sv | 41 ++++
 rtl/hdr_frame_writer_if.sv | 20 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/hdr_frame_writer.sv | 147 ++++++++++++++
 tb/tb_hdr_frame_writer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdr_pkg.sv
// Shared types and constants for the HDR frame writer: FSM states, FIFO entry
// layout, buffer-rotation helper.
package hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SWAP = 2'd2
    } wr_state_t;

    localparam int         NUM_BUFS                = 3;
    localparam logic [1:0] RD_FRAME_NONE           = 2'd3;
    localparam int         WORDS_PER_FRAME_DEFAULT = 38400;
    localparam int         IDX_W                   = 16;

    typedef logic [127:0] word_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic             eof;
        logic [IDX_W-1:0] idx;
        word_t            data;
    } fifo_entry_t;

    // Lowest buffer that is neither being written nor scanned out; a reader
    // index of RD_FRAME_NONE never matches, so only the writer is excluded.
    function automatic logic [1:0] next_buf(input logic [1:0] cur, input logic [1:0] rd);
        logic [1:0] nb;
        nb = 2'd0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if (2'(i) != cur && 2'(i) != rd) nb = 2'(i);
        end
        return nb;
    endfunction

endpackage

// File: rtl/hdr_frame_writer_if.sv
// RAM-controller write port: held request with address/data, busy and ack.
interface hdr_frame_writer_if #(parameter int ADDR_W = 24);

    logic                ram_wr_req;
    logic [ADDR_W-1:0]   ram_wr_addr;
    hdr_pkg::word_t      ram_wr_data;
    logic                ram_busy;
    logic                ram_wr_ack;

    modport master (
        output ram_wr_req, ram_wr_addr, ram_wr_data,
        input  ram_busy, ram_wr_ack
    );

    modport slave (
        input  ram_wr_req, ram_wr_addr, ram_wr_data,
        output ram_busy, ram_wr_ack
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a pop frees its slot in the same
// cycle, so a push while full is accepted when it coincides with a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hdr_frame_writer.sv
// Write-side triple-buffer frame controller: FIFO-buffered words become held
// RAM write requests. Optional drop counter: define HDR_WR_DROP_CNT_EN.
module hdr_frame_writer
    import hdr_pkg::*;
#(
    parameter int WORDS_PER_FRAME = WORDS_PER_FRAME_DEFAULT,
    parameter int FRAME_STRIDE    = 65536,
    parameter int BASE_ADDR       = 0,
    parameter int ADDR_W          = 24,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  word_t               wr_data,
    input  logic [1:0]          rd_frame,
    hdr_frame_writer_if.master  ram,
    output logic [1:0]          last_frame,
    output logic                frame_done,
    output logic                overflow,
    output logic [15:0]         drop_cnt
);

    logic [IDX_W-1:0]  win_cnt;
    logic              win_eof;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              drop;
    wr_state_t         state;
    wr_state_t         state_nxt;
    logic              load;
    logic              do_swap;
    logic              cur_eof;
    logic              eof_orphan;
    logic [1:0]        cur_buf;
    logic [ADDR_W-1:0] addr_q;
    word_t             data_q;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [1:0] buf_idx,
                                                    input logic [IDX_W-1:0] idx);
        longint a;
        a = longint'(BASE_ADDR) + longint'(buf_idx) * longint'(FRAME_STRIDE) + longint'(idx);
        return ADDR_W'(a);
    endfunction

    assign win_eof    = (win_cnt == IDX_W'(WORDS_PER_FRAME - 1));
    assign push_entry = {win_eof, win_cnt, wr_data};
    assign drop       = wr_req && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Window counter advances on dropped words too, keeping idx frame-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      win_cnt <= '0;
        else if (wr_req) win_cnt <= win_eof ? '0 : win_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fifo_pop  = 1'b0;
        do_swap   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !ram.ram_busy) begin
                    load      = 1'b1;
                    state_nxt = ST_REQ;
                end else if (fifo_empty && eof_orphan) begin
                    state_nxt = ST_SWAP;
                end
            end
            ST_REQ: begin
                if (ram.ram_wr_ack) begin
                    fifo_pop  = 1'b1;
                    state_nxt = cur_eof ? ST_SWAP : ST_IDLE;
                end
            end
            ST_SWAP: begin
                do_swap   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_buf    <= 2'd0;
            last_frame <= 2'd2;
            overflow   <= 1'b0;
            eof_orphan <= 1'b0;
        end else begin
            state <= state_nxt;
            if (drop) overflow <= 1'b1;
            // A lost eof still has to close its frame once the FIFO drains.
            if (drop && win_eof) eof_orphan <= 1'b1;
            else if (do_swap)    eof_orphan <= 1'b0;
            if (do_swap) begin
                last_frame <= cur_buf;
                cur_buf    <= next_buf(cur_buf, rd_frame);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            data_q  <= '0;
            cur_eof <= 1'b0;
        end else if (load) begin
            addr_q  <= word_addr(cur_buf, head.idx);
            data_q  <= head.data;
            cur_eof <= head.eof;
        end
    end

    assign ram.ram_wr_req  = (state == ST_REQ);
    assign ram.ram_wr_addr = addr_q;
    assign ram.ram_wr_data = data_q;
    assign frame_done      = (state == ST_SWAP);

`ifdef HDR_WR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_hdr_frame_writer.sv
// Directed bench for hdr_frame_writer (WORDS_PER_FRAME=8, FIFO_DEPTH=4).
module tb_hdr_frame_writer;
    import hdr_pkg::*;

    localparam int WPF    = 8;
    localparam int DEPTH  = 4;
    localparam int STRIDE = 65536;
    localparam int AW     = 24;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_req  = 1'b0;
    word_t       wr_data = '0;
    logic [1:0]  rd_frame = 2'd3;
    logic [1:0]  last_frame;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_cnt;

    hdr_frame_writer_if #(.ADDR_W(AW)) ram_if ();

    hdr_frame_writer #(
        .WORDS_PER_FRAME (WPF),
        .FRAME_STRIDE    (STRIDE),
        .BASE_ADDR       (0),
        .ADDR_W          (AW),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_frame   (rd_frame),
        .ram        (ram_if.master),
        .last_frame (last_frame),
        .frame_done (frame_done),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    bit              auto_ack = 1'b0;
    int              fd_cnt   = 0;
    logic [AW-1:0]   acc_addr [$];
    word_t           acc_data [$];

    initial begin
        ram_if.ram_busy   = 1'b0;
        ram_if.ram_wr_ack = 1'b0;
    end

    // RAM model: acks each request the cycle it is seen, logging address/data.
    always begin
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (auto_ack && ram_if.ram_wr_req && !ram_if.ram_wr_ack) begin
            acc_addr.push_back(ram_if.ram_wr_addr);
            acc_data.push_back(ram_if.ram_wr_data);
            ram_if.ram_wr_ack = 1'b1;
        end else begin
            ram_if.ram_wr_ack = 1'b0;
        end
    end

    function automatic word_t pat(input int i);
        return {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i * 3 + 7), 32'h5A5A0000 + 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input int id);
        wr_data = pat(id);
        wr_req  = 1'b1;
        tick();
        wr_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        acc_addr.delete();
        acc_data.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (acc_addr.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        check(tag, acc_addr.size(), n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int exp_drop4;
    int exp_drop5;
    bit req_seen;

    initial begin
`ifdef HDR_WR_DROP_CNT_EN
        exp_drop4 = 2;
        exp_drop5 = 4;
`else
        exp_drop4 = 0;
        exp_drop5 = 0;
`endif
        // Reset state
        tick();
        check("rst_req",   ram_if.ram_wr_req, 0);
        check("rst_addr",  ram_if.ram_wr_addr, 0);
        check("rst_data",  ram_if.ram_wr_data, 0);
        check("rst_last",  last_frame, 2);
        check("rst_fd",    frame_done, 0);
        check("rst_ovf",   overflow, 0);
        check("rst_drop",  drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Four words, prompt acks
        do_reset();
        auto_ack = 1'b1;
        rd_frame = 2'd3;
        for (int i = 0; i < 4; i++) begin
            send_word(i);
            repeat (3) tick();
        end
        wait_reqs("t1_count", 4, 50);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), acc_addr[i], i);
            check($sformatf("t1_data%0d", i), acc_data[i], pat(i));
        end
        check("t1_fd", fd_cnt, 0);

        // Full frame, reader on buffer 1: next frame goes to buffer 2
        do_reset();
        rd_frame = 2'd1;
        for (int i = 0; i < WPF; i++) begin
            send_word(10 + i);
            repeat (3) tick();
        end
        wait_reqs("t2_count_a", WPF, 80);
        repeat (4) tick();
        check("t2_fd_a",   fd_cnt, 1);
        check("t2_last_a", last_frame, 0);
        for (int i = 0; i < WPF; i++)
            check($sformatf("t2_addr_a%0d", i), acc_addr[i], i);
        for (int i = 0; i < WPF; i++) begin
            send_word(100 + i);
            repeat (3) tick();
        end
        wait_reqs("t2_count_b", 2 * WPF, 80);
        repeat (4) tick();
        for (int i = 0; i < WPF; i++)
            check($sformatf("t2_addr_b%0d", i), acc_addr[WPF + i], 2 * STRIDE + i);
        check("t2_data_b7", acc_data[2 * WPF - 1], pat(100 + WPF - 1));
        check("t2_fd_b",   fd_cnt, 2);
        check("t2_last_b", last_frame, 2);

        // RAM busy blocks new requests
        do_reset();
        rd_frame = 2'd3;
        ram_if.ram_busy = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_word(30 + i);
            if (ram_if.ram_wr_req) req_seen = 1'b1;
        end
        repeat (8) begin
            tick();
            if (ram_if.ram_wr_req) req_seen = 1'b1;
        end
        check("t3_no_req", req_seen, 0);
        ram_if.ram_busy = 1'b0;
        wait_reqs("t3_count", 3, 40);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_addr%0d", i), acc_addr[i], i);
            check($sformatf("t3_data%0d", i), acc_data[i], pat(30 + i));
        end

        // Overflow with ack withheld: DEPTH+2 words, two dropped
        do_reset();
        auto_ack = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) send_word(40 + i);
        tick();
        check("t4_ovf",  overflow, 1);
        check("t4_drop", drop_cnt, exp_drop4);
        check("t4_req",  ram_if.ram_wr_req, 1);
        check("t4_addr", ram_if.ram_wr_addr, 0);
        auto_ack = 1'b1;
        wait_reqs("t4_count", DEPTH, 40);
        repeat (10) tick();
        check("t4_no_extra", acc_addr.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t4_addr%0d", i), acc_addr[i], i);
            check($sformatf("t4_data%0d", i), acc_data[i], pat(40 + i));
        end
        check("t4_fd", fd_cnt, 0);

        // Dropped eof word: frame still closes after the FIFO drains
        do_reset();
        rd_frame = 2'd0;
        auto_ack = 1'b0;
        for (int i = 0; i < WPF; i++) send_word(50 + i);
        tick();
        check("t5_drop", drop_cnt, exp_drop5);
        check("t5_fd_pre", fd_cnt, 0);
        auto_ack = 1'b1;
        wait_reqs("t5_count", DEPTH, 40);
        repeat (6) tick();
        check("t5_fd",   fd_cnt, 1);
        check("t5_last", last_frame, 0);
        send_word(60);
        wait_reqs("t5_count_b", DEPTH + 1, 20);
        check("t5_addr_next", acc_addr[DEPTH], STRIDE);

        // Async reset in the middle of a held request
        auto_ack = 1'b0;
        send_word(70);
        repeat (3) tick();
        check("t6_req_pre",  ram_if.ram_wr_req, 1);
        check("t6_addr_pre", ram_if.ram_wr_addr, STRIDE + 1);
        rst_n = 1'b0;
        #1;
        check("t6_req",  ram_if.ram_wr_req, 0);
        check("t6_addr", ram_if.ram_wr_addr, 0);
        check("t6_data", ram_if.ram_wr_data, 0);
        check("t6_last", last_frame, 2);
        check("t6_ovf",  overflow, 0);
        check("t6_fd",   frame_done, 0);
        check("t6_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        acc_addr.delete();
        acc_data.delete();
        auto_ack = 1'b1;
        send_word(80);
        wait_reqs("t6_count", 1, 20);
        check("t6_addr_post", acc_addr[0], 0);
        check("t6_data_post", acc_data[0], pat(80));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
